aes_spi_slave_link: RTL and testbench
=====================================

# aes_spi_slave_link

Slave-side SPI link for the AES system, directly downstream of the SPI master. It deserialises the 128-bit message and the size-dependent key from the serial line, hands a complete frame to the AES core, and shifts the 128-bit core result back to the master. All logic runs in the system `clk` domain; the serial lines are synchronised and edge-detected internally.

## Interface
- No parameters; widths are fixed by AES: message/result 128, key field 256.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `sclk` in 1: serial bit clock from master (asynchronous to `clk`).
- `cs` in 1: chip select, active low.
- `mosi` in 1: serial data from master.
- `mode` in 1: 0 = encrypt, 1 = decrypt; sampled when the frame completes.
- `size` in 2: key size; 00 = 128, 01 = 192, 10 = 256, 11 = reserved.
- `miso` out 1: serial result to master.
- `core_start` out 1: one-`clk` pulse; frame valid on `core_*`.
- `core_msg` out 128: received message.
- `core_key` out 256: key, left-justified in `[255 -: K]`; unused low bits zero.
- `core_size` out 2, `core_mode` out 1: values latched with the frame.
- `res_valid` in 1: core result strobe.
- `res_data` in 128: core result.
- `busy` out 1: high in any state other than IDLE.
- `frame_err` out 1: sticky; set when `size` = 11 at the key phase; cleared by reset or a new `cs` fall.

## Operation
- `sclk`, `cs` and `mosi` each pass through a 2-FF synchroniser. Rising and falling edges of `sclk` are detected on the synchronised signal.
- Bit order is LSB-first for every field.
- States and transitions:
  - IDLE: `cs` falls → RX_MSG, bit counter = 0, `frame_err` cleared.
  - RX_MSG: each `sclk` rise captures `mosi` into `core_msg[cnt]`. After bit 127 → RX_KEY, counter = 0.
  - RX_KEY: `size` is sampled on entry and K is fixed from it. Size 11 → set `frame_err` and go to DONE. Otherwise each `sclk` rise captures `mosi` into `core_key[256-K+cnt]`. After bit K-1: pulse `core_start`, latch `core_mode`/`core_size`, → WAIT_CORE.
  - WAIT_CORE: `res_valid` latches `res_data` into the shift register → TX, with `miso` = `res_data[0]`.
  - TX: each `sclk` fall advances the index and drives the next bit on `miso`. On the fall after bit 127 → DONE, `miso` = 0.
  - DONE: wait for `cs` high → IDLE.
- `cs` high in any non-IDLE state aborts to IDLE. Abort drives `miso` = 0 and issues no `core_start`. `core_msg`/`core_key` hold their last values.
- `res_valid` outside WAIT_CORE is ignored.
- The bit counter is 9 bits and never wraps within a phase.
- `core_key` is zeroed at the start of each RX_KEY, so stale bits never survive a shorter key.

## Timing
- Reset values: `miso` 0, `core_start` 0, `core_msg` 0, `core_key` 0, `core_size` 00, `core_mode` 0, `busy` 0, `frame_err` 0, state IDLE.
- `sclk` high and low phases must each be ≥ 3 `clk` periods. `mosi` must be stable from ≥ 3 `clk` before to ≥ 3 `clk` after each `sclk` rise.
- Input latency: a pin change is seen 3 `clk` after it occurs (2 synchroniser stages + edge register).
- `core_start` is high exactly 1 `clk`, in the cycle after the capture of the last key bit.
- From `res_valid`, `miso` shows bit 0 within 1 `clk`. Each later bit appears ≤ 3 `clk` after the corresponding `sclk` fall, and is therefore stable at the master's next `sclk` rise.
- A `cs` rise and an `sclk` edge detected in the same `clk`: the abort wins and the edge is discarded.
- Asserting `reset` mid-frame returns everything to reset values immediately.

## Test plan
- Encrypt, size 00: msg 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → one `core_start`; `core_msg` matches msg; `core_key[255:128]` = key and `[127:0]` = 0; `core_mode` 0. Stub result 3925841d02dc09fbdc118597196a0b32 shifts out LSB-first over 128 `sclk` falls.
- Size 01 with key 000102…1617, then size 10 with key 000102…1e1f → key left-justified and trailing bits zero. Run a 256-bit frame, then a 192-bit frame: no stale bits from the 256-bit frame remain.
- Size 11 → `frame_err` = 1 and no `core_start`. The next `cs` fall clears `frame_err`.
- `cs` raised after 70 message bits → IDLE, `busy` 0, no `core_start`. A following full frame completes correctly.
- `res_valid` pulsed during RX_MSG → ignored. Delay `res_valid` 500 `clk` in WAIT_CORE → `miso` stays 0 until the pulse, then shows bit 0.
- `reset` asserted during TX after bit 40 → all outputs at reset values within the same cycle. The next frame is received normally.

Source files
------------

// File: rtl/aes_spi_slave_link.sv
// aes_spi_slave_link: SPI slave front end for the AES core.
// Receives a 128-bit message and a size-dependent key LSB-first, hands the
// frame to the core with a one-cycle start pulse, then shifts the 128-bit
// result back out on miso. All serial inputs are synchronised into clk.
module aes_spi_slave_link (
    input  logic         clk,
    input  logic         reset,
    input  logic         sclk,
    input  logic         cs,
    input  logic         mosi,
    input  logic         mode,
    input  logic [1:0]   size,
    output logic         miso,
    output logic         core_start,
    output logic [127:0] core_msg,
    output logic [255:0] core_key,
    output logic [1:0]   core_size,
    output logic         core_mode,
    input  logic         res_valid,
    input  logic [127:0] res_data,
    output logic         busy,
    output logic         frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        RX_MSG,
        RX_KEY,
        WAIT_CORE,
        TX,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [2:0]     sclk_sync;
    logic [2:0]     cs_sync;
    logic [1:0]     mosi_sync;

    logic           sclk_rise;
    logic           sclk_fall;
    logic           cs_high;
    logic           cs_fall;
    logic           mosi_bit;

    logic [8:0]     cnt;
    logic [1:0]     key_size;
    logic [8:0]     key_len;
    logic [7:0]     key_base;
    logic [7:0]     key_idx;
    logic [127:0]   tx_shift;

    logic           abort;
    logic           msg_last;
    logic           key_last;
    logic           tx_last;

    // Two-stage synchronisers plus one history stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= 3'b000;
            cs_sync   <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            sclk_sync <= {sclk_sync[1:0], sclk};
            cs_sync   <= {cs_sync[1:0], cs};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_high   = cs_sync[1];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign mosi_bit  = mosi_sync[1];

    assign busy      = (state != IDLE);
    assign abort     = (state != IDLE) && cs_high;
    assign msg_last  = (state == RX_MSG) && sclk_rise && (cnt == 9'd127);
    assign key_last  = (state == RX_KEY) && sclk_rise && (cnt == key_len - 9'd1);
    assign tx_last   = (state == TX) && sclk_fall && (cnt == 9'd127);
    assign key_idx   = key_base + cnt[7:0];

    // Key geometry: keys are left-justified, so shorter keys start higher.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        key_len  = 9'd256;
        key_base = 8'd0;
        case (key_size)
            2'b00: begin
                key_len  = 9'd128;
                key_base = 8'd128;
            end
            2'b01: begin
                key_len  = 9'd192;
                key_base = 8'd64;
            end
            default: begin
                key_len  = 9'd256;
                key_base = 8'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a cs rise outside IDLE always wins over any edge.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      if (cs_fall)   state_next = RX_MSG;
                RX_MSG:    if (msg_last)  state_next = (size == 2'b11) ? DONE : RX_KEY;
                RX_KEY:    if (key_last)  state_next = WAIT_CORE;
                WAIT_CORE: if (res_valid) state_next = TX;
                TX:        if (tx_last)   state_next = DONE;
                DONE:                     state_next = DONE;
                default:                  state_next = IDLE;
            endcase
        end
    end

    // Datapath: bit capture, frame hand-off and result shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the frame registers are reset because they drive ports whose reset value is defined.
            core_msg   <= '0;
            core_key   <= '0;
            core_size  <= 2'b00;
            core_mode  <= 1'b0;
            core_start <= 1'b0;
            miso       <= 1'b0;
            frame_err  <= 1'b0;
            cnt        <= '0;
            key_size   <= 2'b00;
            tx_shift   <= '0;
        end else begin
            core_start <= 1'b0;
            if (abort) begin
                miso <= 1'b0;
                cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            cnt       <= '0;
                            frame_err <= 1'b0;
                        end
                    end
                    RX_MSG: begin
                        if (sclk_rise) begin
                            core_msg[cnt[6:0]] <= mosi_bit;
                            if (msg_last) begin
                                cnt      <= '0;
                                key_size <= size;
                                core_key <= '0;
                                if (size == 2'b11) begin
                                    frame_err <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 9'd1;
                            end
                        end
                    end
                    RX_KEY: begin
                        if (sclk_rise) begin
                            core_key[key_idx] <= mosi_bit;
                            if (key_last) begin
                                core_start <= 1'b1;
                                core_mode  <= mode;
                                core_size  <= key_size;
                                cnt        <= '0;
                            end else begin
                                cnt <= cnt + 9'd1;
                            end
                        end
                    end
                    WAIT_CORE: begin
                        if (res_valid) begin
                            tx_shift <= res_data;
                            miso     <= res_data[0];
                            cnt      <= '0;
                        end
                    end
                    TX: begin
                        if (sclk_fall) begin
                            if (tx_last) begin
                                miso <= 1'b0;
                                cnt  <= '0;
                            end else begin
                                tx_shift <= tx_shift >> 1;
                                miso     <= tx_shift[1];
                                cnt      <= cnt + 9'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_spi_slave_link.sv
// Directed bench for aes_spi_slave_link: drives the SPI master side with
// 8-clk bit periods and checks frames, key justification, errors, aborts,
// result shifting and mid-frame reset against hand-written vectors.
module tb_aes_spi_slave_link;

    logic         clk;
    logic         reset;
    logic         sclk;
    logic         cs;
    logic         mosi;
    logic         mode;
    logic [1:0]   size;
    logic         miso;
    logic         core_start;
    logic [127:0] core_msg;
    logic [255:0] core_key;
    logic [1:0]   core_size;
    logic         core_mode;
    logic         res_valid;
    logic [127:0] res_data;
    logic         busy;
    logic         frame_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int start_cnt = 0;

    localparam logic [127:0] MSG_A = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RES_A = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [191:0] KEY_192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] MSG_B = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RES_B = 128'h00112233445566778899aabbccddeeff;

    aes_spi_slave_link dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .mode       (mode),
        .size       (size),
        .miso       (miso),
        .core_start (core_start),
        .core_msg   (core_msg),
        .core_key   (core_key),
        .core_size  (core_size),
        .core_mode  (core_mode),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count clk cycles with core_start high; a clean pulse adds exactly one.
    always @(negedge clk) begin
        if (core_start === 1'b1) start_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One full-duplex bit: mosi set, rise (miso sampled), fall.
    task automatic spi_bit(input logic b, output logic s);
        mosi = b;
        wait_clk(4);
        sclk = 1'b1;
        s = miso;
        wait_clk(4);
        sclk = 1'b0;
    endtask

    task automatic cs_down;
        cs = 1'b0;
        wait_clk(5);
    endtask

    task automatic cs_up;
        cs = 1'b1;
        wait_clk(6);
    endtask

    task automatic send_bits(input logic [255:0] data, input int n);
        logic s;
        for (int i = 0; i < n; i++) spi_bit(data[i], s);
    endtask

    task automatic send_frame(input logic [127:0] msg, input logic [255:0] key, input int klen);
        send_bits({128'h0, msg}, 128);
        send_bits(key, klen);
        wait_clk(4);
    endtask

    task automatic pulse_res(input logic [127:0] d);
        res_data  = d;
        res_valid = 1'b1;
        wait_clk(1);
        res_valid = 1'b0;
        wait_clk(1);
    endtask

    task automatic recv_bits(input int n, output logic [127:0] rx);
        logic s;
        rx = '0;
        for (int i = 0; i < n; i++) begin
            spi_bit(1'b0, s);
            rx[i] = s;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(3);
        total_cnt++;
        if ({miso, core_start, busy, frame_err, core_mode, core_size} !== 7'b0) begin
            $display("FAIL reset_ctrl: got %b expected 0000000", {miso, core_start, busy, frame_err, core_mode, core_size});
        end else pass_cnt++;
        total_cnt++;
        if (core_msg !== 128'h0 || core_key !== 256'h0) begin
            $display("FAIL reset_data: msg %h key %h expected zero", core_msg, core_key);
        end else pass_cnt++;
    endtask

    task automatic test_encrypt_128;
        int s0;
        logic [127:0] rx;
        s0 = start_cnt;
        mode = 1'b0;
        size = 2'b00;
        cs_down();
        send_frame(MSG_A, {128'h0, KEY_A}, 128);
        total_cnt++;
        if (start_cnt - s0 !== 1) begin
            $display("FAIL enc_start_count: got %0d expected 1", start_cnt - s0);
        end else pass_cnt++;
        total_cnt++;
        if (core_msg !== MSG_A) begin
            $display("FAIL enc_msg: got %h expected %h", core_msg, MSG_A);
        end else pass_cnt++;
        total_cnt++;
        if (core_key !== {KEY_A, 128'h0}) begin
            $display("FAIL enc_key: got %h expected %h", core_key, {KEY_A, 128'h0});
        end else pass_cnt++;
        total_cnt++;
        if (core_mode !== 1'b0 || core_size !== 2'b00 || busy !== 1'b1) begin
            $display("FAIL enc_latched: mode %b size %b busy %b expected 0 00 1", core_mode, core_size, busy);
        end else pass_cnt++;
        pulse_res(RES_A);
        total_cnt++;
        if (miso !== RES_A[0]) begin
            $display("FAIL enc_bit0: got %b expected %b", miso, RES_A[0]);
        end else pass_cnt++;
        recv_bits(128, rx);
        total_cnt++;
        if (rx !== RES_A) begin
            $display("FAIL enc_result: got %h expected %h", rx, RES_A);
        end else pass_cnt++;
        wait_clk(5);
        total_cnt++;
        if (miso !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL enc_done: miso %b busy %b expected 0 1", miso, busy);
        end else pass_cnt++;
        cs_up();
        total_cnt++;
        if (busy !== 1'b0) begin
            $display("FAIL enc_idle: busy %b expected 0", busy);
        end else pass_cnt++;
    endtask

    task automatic test_key_sizes;
        mode = 1'b1;
        size = 2'b01;
        cs_down();
        send_frame(MSG_B, {64'h0, KEY_192}, 192);
        total_cnt++;
        if (core_key !== {KEY_192, 64'h0} || core_size !== 2'b01 || core_mode !== 1'b1) begin
            $display("FAIL key192: got %h size %b mode %b expected %h 01 1", core_key, core_size, core_mode, {KEY_192, 64'h0});
        end else pass_cnt++;
        cs_up();
        size = 2'b10;
        cs_down();
        send_frame(MSG_B, KEY_256, 256);
        total_cnt++;
        if (core_key !== KEY_256 || core_size !== 2'b10) begin
            $display("FAIL key256: got %h size %b expected %h 10", core_key, core_size, KEY_256);
        end else pass_cnt++;
        cs_up();
        size = 2'b01;
        cs_down();
        send_frame(MSG_B, {64'h0, KEY_192}, 192);
        total_cnt++;
        if (core_key !== {KEY_192, 64'h0}) begin
            $display("FAIL key_stale: got %h expected %h", core_key, {KEY_192, 64'h0});
        end else pass_cnt++;
        cs_up();
    endtask

    task automatic test_frame_err;
        int s0;
        s0 = start_cnt;
        size = 2'b11;
        cs_down();
        send_bits({128'h0, MSG_B}, 128);
        wait_clk(4);
        send_bits(256'hff, 8);
        total_cnt++;
        if (frame_err !== 1'b1 || start_cnt !== s0 || busy !== 1'b1) begin
            $display("FAIL ferr_set: err %b starts %0d busy %b expected 1 %0d 1", frame_err, start_cnt, busy, s0);
        end else pass_cnt++;
        cs_up();
        total_cnt++;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL ferr_sticky: err %b busy %b expected 1 0", frame_err, busy);
        end else pass_cnt++;
        size = 2'b00;
        cs_down();
        total_cnt++;
        if (frame_err !== 1'b0) begin
            $display("FAIL ferr_clear: got %b expected 0", frame_err);
        end else pass_cnt++;
        cs_up();
    endtask

    task automatic test_abort;
        int s0;
        s0 = start_cnt;
        size = 2'b00;
        mode = 1'b0;
        cs_down();
        send_bits({128'h0, MSG_B}, 70);
        cs_up();
        total_cnt++;
        if (busy !== 1'b0 || start_cnt !== s0 || miso !== 1'b0) begin
            $display("FAIL abort: busy %b starts %0d miso %b expected 0 %0d 0", busy, start_cnt, miso, s0);
        end else pass_cnt++;
        cs_down();
        send_frame(MSG_A, {128'h0, KEY_A}, 128);
        total_cnt++;
        if (core_msg !== MSG_A || core_key !== {KEY_A, 128'h0} || start_cnt !== s0 + 1) begin
            $display("FAIL after_abort: msg %h starts %0d expected %h %0d", core_msg, start_cnt, MSG_A, s0 + 1);
        end else pass_cnt++;
        cs_up();
    endtask

    task automatic test_res_valid;
        int s0;
        int bad;
        s0 = start_cnt;
        size = 2'b00;
        cs_down();
        send_bits({128'h0, MSG_B}, 10);
        pulse_res(RES_B);
        total_cnt++;
        if (miso !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL rv_ignored: miso %b busy %b expected 0 1", miso, busy);
        end else pass_cnt++;
        send_bits({128'h0, MSG_B} >> 10, 118);
        send_bits({128'h0, KEY_A}, 128);
        wait_clk(4);
        total_cnt++;
        if (core_msg !== MSG_B || start_cnt !== s0 + 1) begin
            $display("FAIL rv_frame: msg %h starts %0d expected %h %0d", core_msg, start_cnt, MSG_B, s0 + 1);
        end else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            wait_clk(1);
            if (miso !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0) begin
            $display("FAIL rv_wait_miso: %0d cycles nonzero expected 0", bad);
        end else pass_cnt++;
        pulse_res(RES_B);
        total_cnt++;
        if (miso !== 1'b1) begin
            $display("FAIL rv_bit0: got %b expected 1", miso);
        end else pass_cnt++;
    endtask

    task automatic test_reset_in_tx;
        logic [127:0] rx;
        recv_bits(41, rx);
        total_cnt++;
        if (rx[40:0] !== RES_B[40:0]) begin
            $display("FAIL tx_partial: got %h expected %h", rx[40:0], RES_B[40:0]);
        end else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({miso, core_start, busy, frame_err, core_mode, core_size} !== 7'b0 ||
            core_msg !== 128'h0 || core_key !== 256'h0) begin
            $display("FAIL reset_mid: ctrl %b msg %h key %h expected zero", {miso, core_start, busy, frame_err, core_mode, core_size}, core_msg, core_key);
        end else pass_cnt++;
        cs = 1'b1;
        sclk = 1'b0;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(6);
        mode = 1'b1;
        size = 2'b00;
        cs_down();
        send_frame(MSG_A, {128'h0, KEY_A}, 128);
        total_cnt++;
        if (core_msg !== MSG_A || core_key !== {KEY_A, 128'h0} || core_mode !== 1'b1) begin
            $display("FAIL post_reset_frame: msg %h mode %b expected %h 1", core_msg, core_mode, MSG_A);
        end else pass_cnt++;
        pulse_res(RES_A);
        recv_bits(128, rx);
        total_cnt++;
        if (rx !== RES_A) begin
            $display("FAIL post_reset_result: got %h expected %h", rx, RES_A);
        end else pass_cnt++;
        cs_up();
    endtask

    initial begin
        reset     = 1'b1;
        sclk      = 1'b0;
        cs        = 1'b1;
        mosi      = 1'b0;
        mode      = 1'b0;
        size      = 2'b00;
        res_valid = 1'b0;
        res_data  = '0;
        test_reset();
        test_encrypt_128();
        test_key_sizes();
        test_frame_err();
        test_abort();
        test_res_valid();
        test_reset_in_tx();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
